// File: rtl/weight_loader.sv
// weight_loader: moves the kernel weights for one job, channel by channel,
// from an upstream valid/ready stream into the weight FIFO. Each channel
// begins with a FIFO flush. After the flush completes, exactly N_OF_PIXELS
// beats are written. The block then waits for the core to consume the
// channel before it starts the next one.
module weight_loader #(
  parameter int PIX_WIDTH      = 8,
  parameter int SIZE_OF_WEIGHT = 5,
  parameter int N_OF_PIXELS    = SIZE_OF_WEIGHT * SIZE_OF_WEIGHT,
  parameter int N_CHANNELS     = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [PIX_WIDTH-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          i_full,
  input  logic                          i_request_data,
  input  logic                          i_flush_fin,
  output logic                          o_wr_en,
  output logic [PIX_WIDTH-1:0]          o_data,
  output logic                          o_flush,
  input  logic                          i_next_channel,
  output logic [$clog2(N_CHANNELS):0]   o_ch_idx,
  output logic                          o_busy,
  output logic                          o_channel_loaded,
  output logic                          o_done
);

  localparam int CH_W  = $clog2(N_CHANNELS) + 1;
  localparam int CNT_W = $clog2(N_OF_PIXELS + 1);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_OF_PIXELS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_OF_PIXELS);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_WAIT_FIN,
    S_LOAD,
    S_LOADED,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]      ch_idx_q, ch_idx_d;
  logic                 wr_en_q, wr_en_d;
  logic [PIX_WIDTH-1:0] data_q, data_d;
  logic                 flush_q, flush_d;
  logic                 loaded_q, loaded_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 last_beat;

  // The pixel-count guard stops the FIFO from ever taking more than one
  // channel's worth of pixels per flush. This holds even though the state
  // already leaves LOAD on the final beat.
  assign s_ready   = (state_q == S_LOAD) & i_request_data & ~i_full &
                     (pix_cnt_q < FULL_CNT);
  assign accept    = s_valid & s_ready;
  assign last_beat = accept & (pix_cnt_q == LAST_PIX);

  assign o_wr_en          = wr_en_q;
  assign o_data           = data_q;
  assign o_flush          = flush_q;
  assign o_ch_idx         = ch_idx_q;
  assign o_channel_loaded = loaded_q;
  assign o_done           = done_q;
  assign o_busy           = (state_q != S_IDLE);

  // State register; the synchronous reset returns the block to IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic. Abort overrides every other input,
  // drops the write that would otherwise register, and suppresses all pulses.
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    ch_idx_d  = ch_idx_q;
    wr_en_d   = 1'b0;
    data_d    = '0;
    loaded_d  = 1'b0;
    done_d    = 1'b0;

    if (i_abort) begin
      state_d  = S_IDLE;
      ch_idx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            ch_idx_d = '0;
            state_d  = S_FLUSH;
          end
        end

        S_FLUSH: begin
          state_d = S_WAIT_FIN;
        end

        S_WAIT_FIN: begin
          if (i_flush_fin) begin
            pix_cnt_d = '0;
            state_d   = S_LOAD;
          end
        end

        S_LOAD: begin
          if (accept) begin
            wr_en_d   = 1'b1;
            data_d    = s_data;
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (last_beat) begin
              loaded_d = 1'b1;
              state_d  = S_LOADED;
            end
          end
        end

        S_LOADED: begin
          if (i_next_channel) begin
            if (ch_idx_q == LAST_CH) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              ch_idx_d = ch_idx_q + 1'b1;
              state_d  = S_FLUSH;
            end
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // FLUSH is always a single-cycle state, so entering it is the pulse.
    flush_d = (state_d == S_FLUSH);
  end

  // Registered FIFO-side outputs, pulses, and the channel/pixel counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pix_cnt_q <= '0;
      ch_idx_q  <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      flush_q   <= 1'b0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      ch_idx_q  <= ch_idx_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      flush_q   <= flush_d;
      loaded_q  <= loaded_d;
      done_q    <= done_d;
    end
  end

endmodule
